// File: rtl/med_ctrl.sv
// med_ctrl: control FSM that sequences the MED median core over 9-sample frames
//   CLK  in  : single clock, rising edge
//   RST  in  : synchronous active-high reset
//   DSI  in  : data strobe in, high while the 9 frame samples are presented
//   BYP  out : bypass control to the MED core
//   DSO  out : one-cycle pulse when the median is valid on the MED core output
//   BUSY out : high while a frame is being loaded, sorted or completed
//   ERR  out : one-cycle pulse when a frame is aborted by an early DSI drop
module med_ctrl (
    input  logic CLK,
    input  logic RST,
    input  logic DSI,
    output logic BYP,
    output logic DSO,
    output logic BUSY,
    output logic ERR
);
    typedef enum logic [1:0] {IDLE, LOAD, SORT, DONE} state_t;
    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [5:0] c_q, c_d;
    logic       byp_q, byp_d, dso_q, dso_d, busy_q, busy_d;
    // Four discard phases of 8/7/6/5 zero cycles each followed by 1/2/3/4 one cycles
    function automatic logic sched(input logic [5:0] c);
        return c == 6'd8 || c == 6'd16 || c == 6'd17 ||
               (c >= 6'd24 && c <= 6'd26) || (c >= 6'd32 && c <= 6'd35);
    endfunction
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        case (state_q)
            IDLE: if (DSI) begin
                state_d = LOAD;
                cnt_d   = 4'd1;
            end
            LOAD: if (!DSI) begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end else if (cnt_q == 4'd8) begin
                state_d = SORT;
                cnt_d   = 4'd9;
                c_d     = 6'd0;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
            SORT: if (c_q == 6'd39) state_d = DONE;
                  else c_d = c_q + 6'd1;
            default: state_d = IDLE;
        endcase
        // Sort-phase outputs are precomputed from the next state so they come straight from flops
        byp_d  = state_d == SORT && sched(c_d);
        dso_d  = state_d == DONE;
        busy_d = state_d != IDLE;
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            c_q     <= 6'd0;
            byp_q   <= 1'b0;
            dso_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            byp_q   <= byp_d;
            dso_q   <= dso_d;
            busy_q  <= busy_d;
        end
    end
    // While loading, BYP follows DSI so each sample passes straight into the core; an
    // early DSI drop therefore also forces BYP low in the ERR cycle.
    assign ERR  = !RST && state_q == LOAD && !DSI;
    assign BYP  = !RST && (state_q == SORT ? byp_q : (state_q == IDLE || state_q == LOAD) && DSI);
    assign DSO  = !RST && dso_q;
    assign BUSY = !RST && busy_q;
endmodule

// File: tb/tb_med_ctrl.sv
// tb_med_ctrl: randomized self-checking bench for med_ctrl against a frame-level model
module tb_med_ctrl;
    logic CLK = 1'b0, RST = 1'b1, DSI = 1'b0;
    logic BYP, DSO, BUSY, ERR;
    int   errors = 0, checks = 0, cyc = 0;
    bit   chk_en = 1'b0;
    bit   e_byp, e_dso, e_busy, e_err;
    bit   sched_tab[40];
    int   n = 0, age = 0;
    int   last_dso = -1, last_err = -1, byp_cnt = 0, dso_cnt = 0, s1;

    med_ctrl dut (.CLK(CLK), .RST(RST), .DSI(DSI), .BYP(BYP), .DSO(DSO), .BUSY(BUSY), .ERR(ERR));

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    always @(negedge CLK) if (chk_en) begin
        chk("BYP", int'(BYP), int'(e_byp));
        chk("DSO", int'(DSO), int'(e_dso));
        chk("BUSY", int'(BUSY), int'(e_busy));
        chk("ERR", int'(ERR), int'(e_err));
        if (DSO) begin
            last_dso = cyc;
            dso_cnt++;
        end
        if (ERR) last_err = cyc;
        if (BYP) byp_cnt++;
    end

    // Frame model: n = samples taken (0 = idle), age = cycles since sample 9 was taken
    task automatic tick(input bit r, input bit d);
        RST = r;
        DSI = d;
        e_byp = 0; e_dso = 0; e_busy = 0; e_err = 0;
        if (r) n = 0;
        else if (n == 0) begin
            e_byp = d;
            if (d) n = 1;
        end else if (n < 9) begin
            e_busy = 1;
            if (d) begin
                e_byp = 1;
                n++;
                age = 0;
            end else begin
                e_err = 1;
                n = 0;
            end
        end else begin
            age++;
            e_busy = 1;
            if (age <= 40) e_byp = sched_tab[age-1];
            else begin
                e_dso = 1;
                n = 0;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic run(input int len, input bit d);
        for (int i = 0; i < len; i++) tick(1'b0, d);
    endtask

    initial begin
        int pos = 0;
        for (int p = 0; p < 4; p++) begin
            pos += 8 - p;
            for (int k = 0; k <= p; k++) sched_tab[pos++] = 1'b1;
        end
        tick(1'b1, 1'b0);
        chk_en = 1'b1;
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        run(3, 1'b0);
        // nominal frame
        byp_cnt = 0;
        s1 = cyc;
        run(9, 1'b1);
        run(45, 1'b0);
        chk("nominal_dso_latency", last_dso - s1, 49);
        chk("nominal_byp_count", byp_cnt, 19);
        // abort after 5 samples, then a full frame
        s1 = cyc;
        run(5, 1'b1);
        run(3, 1'b0);
        chk("abort_err_cycle", last_err - s1, 5);
        s1 = cyc;
        run(9, 1'b1);
        run(42, 1'b0);
        chk("after_abort_dso", last_dso - s1, 49);
        // strobe held for 30 cycles
        byp_cnt = 0;
        s1 = cyc;
        run(30, 1'b1);
        run(25, 1'b0);
        chk("long_dsi_dso", last_dso - s1, 49);
        chk("long_dsi_byp_count", byp_cnt, 19);
        // reset at c=20
        s1 = cyc;
        run(9, 1'b1);
        run(20, 1'b0);
        tick(1'b1, 1'b0);
        run(50, 1'b0);
        chk("reset_sort_no_dso", int'(last_dso < s1), 1);
        s1 = cyc;
        run(9, 1'b1);
        run(42, 1'b0);
        chk("after_reset_dso", last_dso - s1, 49);
        // back-to-back random frames with noise on DSI while sorting
        byp_cnt = 0;
        dso_cnt = 0;
        for (int f = 0; f < 1000; f++) begin
            run(9, 1'b1);
            for (int i = 0; i < 41; i++) tick(1'b0, 1'($urandom_range(0, 1)));
        end
        chk("random_dso_count", dso_cnt, 1000);
        chk("random_byp_count", byp_cnt, 19000);
        // fully random strobe and occasional reset
        for (int i = 0; i < 3000; i++)
            tick($urandom_range(0, 39) == 0, $urandom_range(0, 7) != 0);
        tick(1'b1, 1'b0);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
